mod7_feeder: RTL and testbench

MOD7_FEEDER -- requirements
Module: mod7_feeder

---
 rtl/mod7_feeder.sv | 129 ++++++++++++
 tb/tb_mod7_feeder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod7_feeder.sv
// Host-side feeder for a serial mod-7 unit: accepts a 48-bit word, issues Start, streams 8 six-bit chunks MSB-first, and captures the residue.
// Optional build macro MOD7_CHECK_EN adds a local residue fold and drives mismatch at capture.
module mod7_feeder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] data_in,
    output logic        ss_start,
    output logic [5:0]  ss_bus,
    input  logic        ss_ready,
    input  logic [2:0]  ss_result,
    output logic        res_valid,
    output logic [2:0]  res,
    output logic        err,
    output logic        mismatch
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_GAP   = 3'd2,
        S_SEND  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [47:0] shreg;
    logic [2:0]  cnt;      // chunk index in SEND, timeout count in WAIT
    logic [2:0]  res_q;
    logic        err_q;
    logic        accept;
    logic        timeout;

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        ss_start  = 1'b0;
        ss_bus    = 6'd0;
        res_valid = 1'b0;
        accept    = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = ss_ready && !rst;
                if (in_valid && in_ready) begin
                    accept    = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                ss_start  = 1'b1;
                state_nxt = S_GAP;
            end
            S_GAP: state_nxt = S_SEND;
            S_SEND: begin
                ss_bus = shreg[47:42];
                if (cnt == 3'd7) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Capture is visible in the same cycle Ready is seen, so res_valid lands on cycle 11.
                if (ss_ready) begin
                    res_valid = 1'b1;
                    state_nxt = S_IDLE;
                end else if (cnt == 3'd3) begin
                    timeout   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign res = res_valid ? ss_result : res_q;
    assign err = err_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            shreg <= 48'd0;
            cnt   <= 3'd0;
            res_q <= 3'd0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    cnt <= 3'd0;
                    if (accept) shreg <= data_in;
                end
                S_GAP:  cnt <= 3'd0;
                S_SEND: begin
                    shreg <= {shreg[41:0], 6'd0};
                    cnt   <= cnt + 3'd1;   // wraps 7 -> 0 on entry to WAIT
                end
                S_WAIT: begin
                    cnt <= cnt + 3'd1;
                    if (res_valid) res_q <= ss_result;
                    if (timeout)   err_q <= 1'b1;
                end
                default: cnt <= 3'd0;
            endcase
        end
    end

`ifdef MOD7_CHECK_EN
    logic [2:0] r;
    logic [8:0] fold;

    assign fold = {r, ss_bus};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= 3'd0;
        end else if (state == S_GAP) begin
            r <= 3'd0;
        end else if (state == S_SEND) begin
            r <= 3'(fold % 9'd7);
        end
    end

    assign mismatch = res_valid && (ss_result != r);
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_mod7_feeder.sv
// Directed bench for mod7_feeder with a behavioural serial mod-7 unit (nominal, hung, or forced result).
// Build with MOD7_CHECK_EN defined to exercise the mismatch path.
module tb_mod7_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] data_in = 48'd0;
    logic        ss_start;
    logic [5:0]  ss_bus;
    logic        ss_ready;
    logic [2:0]  ss_result;
    logic        res_valid;
    logic [2:0]  res;
    logic        err;
    logic        mismatch;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mod7_feeder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .ss_start(ss_start), .ss_bus(ss_bus),
        .ss_ready(ss_ready), .ss_result(ss_result), .res_valid(res_valid),
        .res(res), .err(err), .mismatch(mismatch)
    );

    // Serial unit model: reassembles the 8 chunks and reduces with %.
    logic        hang = 1'b0;
    logic        force_en = 1'b0;
    logic [2:0]  force_val = 3'd0;
    logic [1:0]  phase;
    logic [3:0]  mcnt;
    logic [47:0] mword;
    logic [47:0] mnext;

    assign mnext = {mword[41:0], ss_bus};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase     <= 2'd0;
            mcnt      <= 4'd0;
            mword     <= 48'd0;
            ss_ready  <= 1'b1;
            ss_result <= 3'd0;
        end else if (ss_start) begin
            phase    <= 2'd1;
            mcnt     <= 4'd0;
            mword    <= 48'd0;
            ss_ready <= 1'b0;
        end else if (phase == 2'd1) begin
            phase <= 2'd2;
        end else if (phase == 2'd2) begin
            mword <= mnext;
            mcnt  <= mcnt + 4'd1;
            if (mcnt == 4'd7) begin
                phase     <= 2'd0;
                ss_result <= force_en ? force_val : 3'(mnext % 48'd7);
                if (!hang) ss_ready <= 1'b1;
            end
        end else if (!hang) begin
            ss_ready <= 1'b1;
        end
    end

    // Per-transaction observations, indexed by cycle k after the accepting edge.
    logic [5:0] got_bus [8];
    logic [5:0] bus_gap, bus_wait;
    int         rv_cycle, rv_count, start_first, start_cnt;
    logic [2:0] res_rv, res_end;
    logic       mm_rv, err14, err15;
    logic [2:0] res15;
    logic [14:0] rst_snap;
    logic       accepted;

    task automatic do_txn(input logic [47:0] d, input int abort_k);
        int w;
        rv_cycle = -1; rv_count = 0; start_first = -1; start_cnt = 0;
        res_rv = 3'd0; mm_rv = 1'b0; rst_snap = '1; accepted = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = d;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_wait: in_ready stayed %b, need 1 within 20 cycles", in_ready);
            in_valid = 1'b0;
            return;
        end
        accepted = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            if (ss_start) begin
                start_cnt++;
                if (start_first < 0) start_first = k;
            end
            if (k >= 3 && k <= 10) got_bus[k-3] = ss_bus;
            if (k == 2)  bus_gap  = ss_bus;
            if (k == 11) bus_wait = ss_bus;
            if (k == 14) err14 = err;
            if (k == 15) begin err15 = err; res15 = res; end
            if (k == 16) res_end = res;
            if (res_valid) begin
                rv_count++;
                if (rv_cycle < 0) begin
                    rv_cycle = k; res_rv = res; mm_rv = mismatch;
                end
            end
            if (abort_k > 0 && k == abort_k) begin
                rst = 1'b1;
                #1;
                rst_snap = {in_ready, ss_start, ss_bus, res, res_valid, err, mismatch};
            end
            if (abort_k > 0 && k == abort_k + 2) rst = 1'b0;
        end
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({in_ready, ss_start, ss_bus, res, res_valid, err, mismatch} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b need 0", {in_ready, ss_start, ss_bus, res, res_valid, err, mismatch});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_ready: in_ready=%b need 1", in_ready);
        end
    endtask

    task automatic test_nominal;
        do_txn(48'd100, 0);
        n_cmp++;
        if (rv_cycle != 11 || res_rv !== 3'd2 || mm_rv !== 1'b0) begin
            n_bad++;
            $display("FAIL nominal_100: cycle=%0d res=%0d mm=%b need cycle 11 res 2 mm 0", rv_cycle, res_rv, mm_rv);
        end
        n_cmp++;
        if (start_first != 1 || start_cnt != 1) begin
            n_bad++;
            $display("FAIL start_pulse: first=%0d count=%0d need 1/1", start_first, start_cnt);
        end
        n_cmp++;
        if (got_bus[6] !== 6'd1 || got_bus[7] !== 6'h24 || got_bus[0] !== 6'd0) begin
            n_bad++;
            $display("FAIL bus_100: c0=%h c6=%h c7=%h need 00 01 24", got_bus[0], got_bus[6], got_bus[7]);
        end
        n_cmp++;
        if (rv_count != 1 || res_end !== 3'd2) begin
            n_bad++;
            $display("FAIL res_hold: pulses=%0d res=%0d need 1 pulse res 2", rv_count, res_end);
        end
    endtask

    task automatic test_msb;
        do_txn(48'h8000_0000_0000, 0);
        n_cmp++;
        if (got_bus[0] !== 6'h20) begin
            n_bad++;
            $display("FAIL msb_chunk0: got %h need 20", got_bus[0]);
        end
        for (int i = 1; i < 8; i++) begin
            n_cmp++;
            if (got_bus[i] !== 6'h00) begin
                n_bad++;
                $display("FAIL msb_chunk%0d: got %h need 00", i, got_bus[i]);
            end
        end
        n_cmp++;
        if (rv_cycle != 11 || res_rv !== 3'd4) begin
            n_bad++;
            $display("FAIL msb_res: cycle=%0d res=%0d need 11/4", rv_cycle, res_rv);
        end
    endtask

    task automatic test_ones;
        logic ok;
        do_txn(48'hFFFF_FFFF_FFFF, 0);
        ok = 1'b1;
        for (int i = 0; i < 8; i++) if (got_bus[i] !== 6'h3F) ok = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL ones_chunks: c0=%h c3=%h c7=%h need all 3f", got_bus[0], got_bus[3], got_bus[7]);
        end
        n_cmp++;
        if (bus_gap !== 6'd0 || bus_wait !== 6'd0) begin
            n_bad++;
            $display("FAIL bus_idle: gap=%h wait=%h need 00 00", bus_gap, bus_wait);
        end
        n_cmp++;
        if (rv_cycle != 11 || res_rv !== 3'd0) begin
            n_bad++;
            $display("FAIL ones_res: cycle=%0d res=%0d need 11/0", rv_cycle, res_rv);
        end
    endtask

    task automatic test_timeout;
        hang = 1'b1;
        do_txn(48'd100, 0);
        n_cmp++;
        if (rv_count != 0) begin
            n_bad++;
            $display("FAIL timeout_no_valid: pulses=%0d need 0", rv_count);
        end
        n_cmp++;
        if (err14 !== 1'b0 || err15 !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_err: c14=%b c15=%b need 0 1", err14, err15);
        end
        n_cmp++;
        if (res15 !== 3'd0) begin
            n_bad++;
            $display("FAIL timeout_res: res=%0d need 0 (unchanged)", res15);
        end
    endtask

    task automatic test_busy_ignore;
        int seen;
        seen = 0;
        in_valid = 1'b1;
        data_in  = 48'd9;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || ss_start !== 1'b0) seen++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL busy_ignore: %0d cycles with in_ready/ss_start high, need 0", seen);
        end
        hang = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (err !== 1'b1 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky: err=%b in_ready=%b need 1 1", err, in_ready);
        end
    endtask

    task automatic test_reset_mid;
        do_txn(48'd100, 6);
        n_cmp++;
        if (rst_snap !== 15'd0) begin
            n_bad++;
            $display("FAIL midrst_outputs: got %b need 0", rst_snap);
        end
        n_cmp++;
        if (rv_count != 0) begin
            n_bad++;
            $display("FAIL midrst_no_valid: pulses=%0d need 0", rv_count);
        end
        do_txn(48'd65, 0);
        n_cmp++;
        if (rv_cycle != 11 || res_rv !== 3'd2 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL after_rst_65: cycle=%0d res=%0d err=%b need 11/2/0", rv_cycle, res_rv, err);
        end
    endtask

    task automatic test_check;
        logic mm_exp;
`ifdef MOD7_CHECK_EN
        mm_exp = 1'b1;
`else
        mm_exp = 1'b0;
`endif
        force_en  = 1'b1;
        force_val = 3'd5;
        do_txn(48'd7, 0);
        force_en  = 1'b0;
        n_cmp++;
        if (rv_cycle != 11 || res_rv !== 3'd5 || mm_rv !== mm_exp) begin
            n_bad++;
            $display("FAIL forced_7: cycle=%0d res=%0d mm=%b need 11/5/%b", rv_cycle, res_rv, mm_rv, mm_exp);
        end
    endtask

    task automatic test_back_to_back;
        do_txn(48'd123456789, 0);
        n_cmp++;
        if (!accepted || rv_cycle != 11 || res_rv !== 3'd1 || mm_rv !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_first: cycle=%0d res=%0d mm=%b need 11/1/0", rv_cycle, res_rv, mm_rv);
        end
        do_txn(48'hFFFF_FFFF_FFFE, 0);
        n_cmp++;
        if (!accepted || rv_cycle != 11 || res_rv !== 3'd6 || mm_rv !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_second: cycle=%0d res=%0d mm=%b need 11/6/0", rv_cycle, res_rv, mm_rv);
        end
    endtask

    initial begin
        #1;
        test_reset;
        test_nominal;
        test_msb;
        test_ones;
        test_timeout;
        test_busy_ignore;
        test_reset_mid;
        test_check;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
